// File: rtl/adbg_crc32_rx_check_if.sv
// Bundles the control, serial-input and status signals of the CRC-32 receive checker.
//   master: drives clr, start, len_bits, bit_in and bit_valid; observes the status outputs.
//   slave : the checker itself; drives busy, done, crc_ok, crc_err and crc_value.
interface adbg_crc32_rx_check_if #(
  parameter int unsigned LEN_W = 16
);
  logic             clr;
  logic             start;
  logic [LEN_W-1:0] len_bits;
  logic             bit_in;
  logic             bit_valid;
  logic             busy;
  logic             done;
  logic             crc_ok;
  logic             crc_err;
  logic [31:0]      crc_value;

  modport master (
    output clr, start, len_bits, bit_in, bit_valid,
    input  busy, done, crc_ok, crc_err, crc_value
  );

  modport slave (
    input  clr, start, len_bits, bit_in, bit_valid,
    output busy, done, crc_ok, crc_err, crc_value
  );
endinterface

// File: rtl/adbg_crc32_rx_check.sv
// Serial CRC-32 receive checker for the JTAG write path.
// Takes a frame of len_bits payload bits followed by a 32-bit CRC sent LSB first, one bit per
// cycle with bit_valid high. The running CRC (reflected poly 0xEDB88320, no final XOR) is
// compared bit by bit against the trailing CRC; done pulses once and crc_ok/crc_err hold the
// verdict until the next start or clr.
// Ports:
//   clk  - rising-edge clock
//   rstn - asynchronous reset, active high
//   bus  - slave modport: clr, start, len_bits, bit_in, bit_valid in;
//          busy, done, crc_ok, crc_err, crc_value out
module adbg_crc32_rx_check #(
  parameter int unsigned LEN_W    = 16,
  parameter logic [31:0] CRC_INIT = 32'hFFFF_FFFF
) (
  input  logic                   clk,
  input  logic                   rstn,
  adbg_crc32_rx_check_if.slave   bus
);

  // Bit 31 of the polynomial doubles as new[31] = fb, since the shifted-in MSB is zero.
  localparam logic [31:0] Poly = 32'hEDB8_8320;

  typedef enum logic [1:0] {StIdle, StData, StCrc} state_e;

  state_e           state_q, state_d;
  logic [31:0]      crc_q, crc_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             mismatch_q, mismatch_d;
  logic             done_q, done_d;
  logic             ok_q, ok_d;
  logic             err_q, err_d;

  logic             fb;
  logic [31:0]      crc_step;
  logic             mismatch_fin;
  logic             last_crc_bit;

  assign fb           = bus.bit_in ^ crc_q[0];
  assign crc_step     = (crc_q >> 1) ^ (fb ? Poly : 32'h0);
  // Includes the current bit's compare so the final bit counts toward the verdict.
  assign mismatch_fin = mismatch_q | (bus.bit_in != crc_q[cnt_q[4:0]]);
  assign last_crc_bit = (cnt_q[4:0] == 5'd31);

  // State register
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state_q    <= StIdle;
      crc_q      <= CRC_INIT;
      cnt_q      <= '0;
      mismatch_q <= 1'b0;
      done_q     <= 1'b0;
      ok_q       <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      crc_q      <= crc_d;
      cnt_q      <= cnt_d;
      mismatch_q <= mismatch_d;
      done_q     <= done_d;
      ok_q       <= ok_d;
      err_q      <= err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (bus.clr) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            state_d = (bus.len_bits == '0) ? StCrc : StData;
          end
        end
        StData: begin
          if (bus.bit_valid && (cnt_q == LEN_W'(1))) begin
            state_d = StCrc;
          end
        end
        StCrc: begin
          if (bus.bit_valid && last_crc_bit) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Datapath and flag next-state
  always_comb begin
    crc_d      = crc_q;
    cnt_d      = cnt_q;
    mismatch_d = mismatch_q;
    done_d     = 1'b0;
    ok_d       = ok_q;
    err_d      = err_q;
    if (bus.clr) begin
      crc_d      = CRC_INIT;
      cnt_d      = '0;
      mismatch_d = 1'b0;
      ok_d       = 1'b0;
      err_d      = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            crc_d      = CRC_INIT;
            cnt_d      = bus.len_bits;  // zero length lands in StCrc with cnt already 0
            mismatch_d = 1'b0;
            ok_d       = 1'b0;
            err_d      = 1'b0;
          end
        end
        StData: begin
          if (bus.bit_valid) begin
            crc_d = crc_step;
            cnt_d = cnt_q - LEN_W'(1);  // reaches 0 exactly when entering StCrc
          end
        end
        StCrc: begin
          if (bus.bit_valid) begin
            mismatch_d = mismatch_fin;
            if (last_crc_bit) begin
              cnt_d  = '0;
              done_d = 1'b1;
              ok_d   = ~mismatch_fin;
              err_d  = mismatch_fin;
            end else begin
              cnt_d = cnt_q + LEN_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs
  always_comb begin
    bus.busy      = (state_q != StIdle);
    bus.done      = done_q;
    bus.crc_ok    = ok_q;
    bus.crc_err   = err_q;
    bus.crc_value = crc_q;
  end

endmodule

// File: tb/tb_adbg_crc32_rx_check.sv
// Self-checking bench for adbg_crc32_rx_check: a vector table of whole frames, a scoreboard
// queue of expected verdicts popped on every done pulse, and hand-written corner sequences
// (clr mid-frame, start while busy, start during done, async reset mid-CRC).
module tb_adbg_crc32_rx_check;

  logic clk  = 1'b0;
  logic rstn = 1'b1;

  adbg_crc32_rx_check_if #(.LEN_W(16)) bus ();

  adbg_crc32_rx_check #(
    .LEN_W   (16),
    .CRC_INIT(32'hFFFF_FFFF)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [15:0]  len;
    logic [71:0]  data;      // bit k is the k-th payload bit on the wire
    logic [31:0]  crc;       // sent LSB first
    logic [31:0]  exp_data;  // crc_value expected once the payload is consumed
    logic         exp_ok;
    bit           gaps;
  } vec_t;

  typedef struct {
    string name;
    logic  ok;
    logic  err;
  } exp_t;

  vec_t vecs[7];
  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push_exp(input string name, input logic ok);
    exp_t e;
    e.name = name;
    e.ok   = ok;
    e.err  = ~ok;
    sb.push_back(e);
  endtask

  // Every done pulse must correspond to a queued expectation.
  always @(negedge clk) begin
    if (!rstn && bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1, expected no done pulse");
      end else begin
        mon_e = sb.pop_front();
        check({mon_e.name, "_crc_ok"}, {31'b0, bus.crc_ok}, {31'b0, mon_e.ok});
        check({mon_e.name, "_crc_err"}, {31'b0, bus.crc_err}, {31'b0, mon_e.err});
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input int gap);
    for (int k = 0; k < gap; k++) begin
      bus.bit_valid = 1'b0;
      bus.bit_in    = 1'($urandom);
      cyc();
    end
    bus.bit_valid = 1'b1;
    bus.bit_in    = b;
    cyc();
    bus.bit_valid = 1'b0;
  endtask

  task automatic start_frame(input logic [15:0] len);
    bus.start    = 1'b1;
    bus.len_bits = len;
    cyc();
    bus.start    = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input bit mid_start, input bit b2b);
    int g;
    push_exp(v.name, v.exp_ok);
    start_frame(v.len);
    check({v.name, "_busy_after_start"}, {31'b0, bus.busy}, 32'd1);
    for (int i = 0; i < int'(v.len); i++) begin
      g = v.gaps ? int'($urandom_range(1, 5)) : 0;
      if (mid_start && i == 20) begin
        bus.start    = 1'b1;
        bus.len_bits = 16'd5;
      end
      send_bit(v.data[i], g);
      bus.start = 1'b0;
    end
    check({v.name, "_crc_after_data"}, bus.crc_value, v.exp_data);
    check({v.name, "_busy_in_crc"}, {31'b0, bus.busy}, 32'd1);
    for (int i = 0; i < 32; i++) begin
      g = v.gaps ? int'($urandom_range(1, 5)) : 0;
      if (i == 31) check({v.name, "_no_early_done"}, {31'b0, bus.done}, 32'd0);
      send_bit(v.crc[i], g);
    end
    check({v.name, "_done_pulse"}, {31'b0, bus.done}, 32'd1);
    check({v.name, "_busy_low_at_done"}, {31'b0, bus.busy}, 32'd0);
    if (b2b) begin
      bus.start    = 1'b1;
      bus.len_bits = 16'd0;
    end
    cyc();
    bus.start = 1'b0;
    check({v.name, "_done_one_cycle"}, {31'b0, bus.done}, 32'd0);
    if (b2b) begin
      check({v.name, "_b2b_ok_cleared"}, {31'b0, bus.crc_ok}, 32'd0);
      check({v.name, "_b2b_err_cleared"}, {31'b0, bus.crc_err}, 32'd0);
      check({v.name, "_b2b_busy"}, {31'b0, bus.busy}, 32'd1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{"ascii_ok",   16'd72, 72'h393837363534333231, 32'h340B_C6D9, 32'h340B_C6D9,
                1'b1, 1'b0};
    vecs[1] = '{"ascii_b31",  16'd72, 72'h393837363534333231, 32'hB40B_C6D9, 32'h340B_C6D9,
                1'b0, 1'b0};
    vecs[2] = '{"ascii_b0",   16'd72, 72'h393837363534333231, 32'h340B_C6D8, 32'h340B_C6D9,
                1'b0, 1'b0};
    vecs[3] = '{"zero_byte",  16'd8,  72'h0, 32'h2DFD_1072, 32'h2DFD_1072, 1'b1, 1'b0};
    vecs[4] = '{"zero_gaps",  16'd8,  72'h0, 32'h2DFD_1072, 32'h2DFD_1072, 1'b1, 1'b1};
    vecs[5] = '{"len0_ok",    16'd0,  72'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0};
    vecs[6] = '{"len0_err",   16'd0,  72'h0, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0};

    bus.clr       = 1'b0;
    bus.start     = 1'b0;
    bus.len_bits  = '0;
    bus.bit_in    = 1'b0;
    bus.bit_valid = 1'b0;

    // Reset values while reset is held.
    #12;
    check("rst_busy", {31'b0, bus.busy}, 32'd0);
    check("rst_done", {31'b0, bus.done}, 32'd0);
    check("rst_crc_ok", {31'b0, bus.crc_ok}, 32'd0);
    check("rst_crc_err", {31'b0, bus.crc_err}, 32'd0);
    check("rst_crc_value", bus.crc_value, 32'hFFFF_FFFF);
    @(posedge clk);
    #1;
    rstn = 1'b0;

    // Bits offered in IDLE must be ignored.
    for (int i = 0; i < 4; i++) send_bit(1'b1, 0);
    cyc();
    check("idle_bits_ignored", bus.crc_value, 32'hFFFF_FFFF);
    check("idle_not_busy", {31'b0, bus.busy}, 32'd0);

    foreach (vecs[i]) run_vec(vecs[i], 1'b0, 1'b0);

    // clr after 40 of 72 data bits: back to IDLE, no done.
    start_frame(16'd72);
    for (int i = 0; i < 40; i++) send_bit(vecs[0].data[i], 0);
    bus.clr = 1'b1;
    cyc();
    bus.clr = 1'b0;
    check("clr_busy", {31'b0, bus.busy}, 32'd0);
    check("clr_crc_value", bus.crc_value, 32'hFFFF_FFFF);
    check("clr_no_done", {31'b0, bus.done}, 32'd0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 0);
    check("clr_idle_hold", bus.crc_value, 32'hFFFF_FFFF);
    run_vec(vecs[0], 1'b0, 1'b0);

    // start pulsed mid-DATA is ignored.
    vecs[0].name = "mid_start";
    run_vec(vecs[0], 1'b1, 1'b0);

    // start in the done cycle is accepted; then finish that zero-length frame.
    vecs[5].name = "b2b_first";
    run_vec(vecs[5], 1'b0, 1'b1);
    push_exp("b2b_second", 1'b1);
    for (int i = 0; i < 32; i++) send_bit(1'b1, 0);
    check("b2b_second_done", {31'b0, bus.done}, 32'd1);
    cyc();

    // Async reset mid-CRC takes effect before the next clock edge.
    start_frame(16'd72);
    for (int i = 0; i < 72; i++) send_bit(vecs[0].data[i], 0);
    for (int i = 0; i < 10; i++) send_bit(vecs[0].crc[i], 0);
    check("pre_rst_busy", {31'b0, bus.busy}, 32'd1);
    #3;
    rstn = 1'b1;
    #1;
    check("async_rst_busy", {31'b0, bus.busy}, 32'd0);
    check("async_rst_crc_value", bus.crc_value, 32'hFFFF_FFFF);
    check("async_rst_done", {31'b0, bus.done}, 32'd0);
    @(posedge clk);
    #1;
    rstn = 1'b0;
    for (int i = 0; i < 40; i++) send_bit(1'(i), 0);
    check("post_rst_idle", {31'b0, bus.busy}, 32'd0);

    cyc();
    check("scoreboard_drained", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/adbg_crc32_rx_check.md
Name: adbg_crc32_rx_check

Overview:
Serial CRC-32 receive checker for the debug module's JTAG write path. It consumes a TDI bit stream one bit per qualified cycle: a programmed number of payload bits, then a 32-bit CRC sent LSB first. It accumulates the CRC over the payload, compares the trailing 32 bits against it, and reports match or mismatch. It is the receiving end of the bit-serial reflected CRC-32 generator used on the TDO read path (same polynomial, same bit order).

Parameters:
LEN_W, 16, width of len_bits; maximum payload is 2^LEN_W-1 bits
CRC_INIT, 32'hFFFFFFFF, CRC register value at reset, clr and start

Ports:
clk  input  1  clock, rising edge
rstn  input  1  reset, asynchronous, active-high (rstn=1 resets)
clr  input  1  synchronous abort; returns to IDLE and reloads CRC_INIT
start  input  1  one-cycle pulse; begins a frame and samples len_bits
len_bits  input  LEN_W  payload length in bits, 0 allowed
bit_in  input  1  serial data/CRC bit (TDI)
bit_valid  input  1  qualifies bit_in for this cycle (JTAG shift-DR strobe)
busy  output  1  high in DATA and CRC states
done  output  1  one-cycle pulse after the last CRC bit is consumed
crc_ok  output  1  sticky; frame CRC matched; cleared by start/clr
crc_err  output  1  sticky; frame CRC mismatched; cleared by start/clr
crc_value  output  32  running CRC register; frozen during the CRC phase

Behaviour:
- Reset (rstn=1, async): state IDLE; crc=CRC_INIT; bit counter=0; mismatch=0; busy=0, done=0, crc_ok=0, crc_err=0; crc_value=CRC_INIT.
- Priority per clock: rstn > clr > start (IDLE only) > bit_valid processing.
- States: IDLE, DATA, CRC.
- IDLE:
  - start=1: crc<=CRC_INIT, mismatch<=0, crc_ok<=0, crc_err<=0, cnt<=len_bits.
  - Go to DATA if len_bits!=0, otherwise go to CRC with cnt<=0.
  - bit_valid is ignored in IDLE.
- DATA: on bit_valid=1, update the CRC with fb = bit_in ^ crc[0]:
  - new[i] = crc[i+1] ^ fb for i in {5,8,9,15,19,20,21,23,24,26,27,29,30}
  - new[i] = crc[i+1] for all other i < 31
  - new[31] = fb
  - This is reflected polynomial 0xEDB88320, LSB first, no final XOR.
  - cnt decrements. When cnt==1 and bit_valid=1, go to CRC with cnt<=0.
  - bit_valid=0: hold all state.
- CRC: crc is frozen. On bit_valid=1:
  - Compare bit_in with crc[cnt]; any inequality sets mismatch.
  - cnt increments 0..31.
  - On the bit with cnt==31: next cycle done=1 for one cycle, crc_ok=!mismatch_final, crc_err=mismatch_final (the last bit's compare is included), then go to IDLE.
- start while busy: ignored; the frame continues.
- start in the same cycle done pulses: accepted (state is already IDLE); crc_ok/crc_err clear that edge.
- clr mid-frame: next edge goes to IDLE, crc=CRC_INIT, flags cleared, no done pulse.
- Async reset mid-frame: immediate return to reset values.
- Latency: done is one clock after the edge that consumes the 32nd CRC bit. crc_ok/crc_err become valid in the same cycle as done and hold until the next start/clr.
- busy: 1 from the edge after start until the edge done asserts; 0 while done is high.
- No bits are consumed while not busy; the counter never wraps.

Test Plan:
- ASCII "123456789" (72 bits, each byte LSB first), len_bits=72, followed by CRC 0x340BC6D9 LSB first -> after data crc_value=0x340BC6D9; done pulse; crc_ok=1, crc_err=0.
- Same frame with CRC bit 31 flipped (0xB40BC6D9) -> done; crc_ok=0, crc_err=1. Repeat with bit 0 flipped -> same result.
- Single byte 0x00, len_bits=8, CRC 0x2DFD1072 -> crc_ok=1. Insert bit_valid=0 gaps of 1-5 cycles between bits -> identical result and done timing relative to the last valid bit.
- len_bits=0, CRC stream 0xFFFFFFFF -> goes directly to CRC, crc_ok=1. Stream 0x00000000 -> crc_err=1.
- Assert clr after 40 of 72 data bits -> next cycle IDLE, busy=0, crc_value=0xFFFFFFFF, no done. Then a full valid frame -> crc_ok=1.
- start pulsed mid-DATA -> ignored, frame completes normally. Assert rstn mid-CRC -> outputs go to reset values asynchronously, before the next clk edge.
